pwm_status_report: RTL and testbench

//   Transmit-side counterpart of the PWM parameter path. Keeps a shadow copy of the

---
 rtl/pwm_status_report.sv | 177 +++++++++++++++++
 tb/tb_pwm_status_report.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_status_report.sv
// Shadows the last applied PWM config of every channel and, on request, streams it
// out as 5-word status frames (one frame per channel) on an AXI-Stream master.
module pwm_status_report #(
    parameter int ID_PWM_STATUS = 1,
    parameter int NUM_CH        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_config_vld,
    input  logic [7:0]  pwm_config_channel,
    input  logic        pwm_en,
    input  logic [27:0] pwm_period,
    input  logic [27:0] pwm_hlevel,
    input  logic        rpt_req,
    input  logic [7:0]  rpt_channel,
    output logic        rpt_busy,
    output logic [31:0] tx_axis_udp_tdata,
    output logic        tx_axis_udp_tvalid,
    output logic        tx_axis_udp_tlast,
    output logic [7:0]  tx_axis_udp_tuser,
    input  logic        tx_axis_udp_tready
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    typedef struct packed {
        logic        en;
        logic [27:0] period;
        logic [27:0] hlevel;
    } cfg_t;

    cfg_t        shadow_q [NUM_CH];
    cfg_t        shadow_d [NUM_CH];
    cfg_t        frame_q, frame_d;
    state_t      state_q, state_d;
    logic        all_mode_q, all_mode_d;
    logic [7:0]  cur_ch_q, cur_ch_d;
    logic [2:0]  word_cnt_q, word_cnt_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;

    logic          cfg_in_range;
    logic          req_single;
    logic          req_all;
    logic          more_ch;
    logic          handshake;
    logic [CW-1:0] cfg_idx;
    logic [CW-1:0] cur_idx;

    assign cfg_in_range = ({1'b0, pwm_config_channel} < 9'(NUM_CH));
    assign req_single   = ({1'b0, rpt_channel} < 9'(NUM_CH));
    assign req_all      = (rpt_channel == 8'hFF);
    assign more_ch      = ({1'b0, cur_ch_q} < 9'(NUM_CH - 1));
    assign handshake    = tvalid_q && tx_axis_udp_tready;
    // Both indices are only used once known to be below NUM_CH.
    assign cfg_idx      = pwm_config_channel[CW-1:0];
    assign cur_idx      = cur_ch_q[CW-1:0];

    function automatic logic [31:0] frame_word(input logic [2:0] idx,
                                               input logic [7:0] ch,
                                               input cfg_t       cfg);
        logic [31:0] w;
        case (idx)
            3'd0:    w = {24'b0, ch};
            3'd1:    w = {4'b0, cfg.period};
            3'd2:    w = {4'b0, cfg.hlevel};
            3'd4:    w = {31'b0, cfg.en};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Capture runs in every state; a LOAD in the same cycle still reads the old value.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (pwm_config_vld && cfg_in_range) begin
            shadow_d[cfg_idx] = {pwm_en, pwm_period, pwm_hlevel};
        end
    end

    always_comb begin
        state_d    = state_q;
        all_mode_d = all_mode_q;
        cur_ch_d   = cur_ch_q;
        word_cnt_d = word_cnt_q;
        frame_d    = frame_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        case (state_q)
            ST_IDLE: begin
                if (rpt_req && (req_single || req_all)) begin
                    state_d    = ST_LOAD;
                    all_mode_d = req_all;
                    cur_ch_d   = req_all ? 8'd0 : rpt_channel;
                end
            end
            ST_LOAD: begin
                frame_d    = shadow_q[cur_idx];
                word_cnt_d = 3'd0;
                tdata_d    = frame_word(3'd0, cur_ch_q, shadow_q[cur_idx]);
                tvalid_d   = 1'b1;
                tlast_d    = 1'b0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    if (word_cnt_q == 3'd4) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tdata_d  = 32'd0;
                        if (all_mode_q && more_ch) begin
                            cur_ch_d = cur_ch_q + 8'd1;
                            state_d  = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 3'd1;
                        tdata_d    = frame_word(word_cnt_q + 3'd1, cur_ch_q, frame_q);
                        tlast_d    = (word_cnt_q == 3'd3);
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tdata_d  = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            all_mode_q <= 1'b0;
            cur_ch_q   <= 8'd0;
            word_cnt_q <= 3'd0;
            frame_q    <= '0;
            tdata_q    <= 32'd0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            state_q    <= state_d;
            all_mode_q <= all_mode_d;
            cur_ch_q   <= cur_ch_d;
            word_cnt_q <= word_cnt_d;
            frame_q    <= frame_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

    assign rpt_busy           = (state_q != ST_IDLE);
    assign tx_axis_udp_tdata  = tdata_q;
    assign tx_axis_udp_tvalid = tvalid_q;
    assign tx_axis_udp_tlast  = tlast_q;
    assign tx_axis_udp_tuser  = 8'(ID_PWM_STATUS);

endmodule

// File: tb/tb_pwm_status_report.sv
// Bench for pwm_status_report: hand tables, corner sequences and random reports
// checked against a per-channel config model and an expected-word queue.
module tb_pwm_status_report;

    localparam int NUM_CH = 8;
    localparam int ID     = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_config_vld;
    logic [7:0]  pwm_config_channel;
    logic        pwm_en;
    logic [27:0] pwm_period;
    logic [27:0] pwm_hlevel;
    logic        rpt_req;
    logic [7:0]  rpt_channel;
    logic        rpt_busy;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tuser;
    logic        tready;

    always #5 clk = ~clk;

    pwm_status_report #(.ID_PWM_STATUS(ID), .NUM_CH(NUM_CH)) dut (
        .clk                (clk),
        .rst                (rst),
        .pwm_config_vld     (pwm_config_vld),
        .pwm_config_channel (pwm_config_channel),
        .pwm_en             (pwm_en),
        .pwm_period         (pwm_period),
        .pwm_hlevel         (pwm_hlevel),
        .rpt_req            (rpt_req),
        .rpt_channel        (rpt_channel),
        .rpt_busy           (rpt_busy),
        .tx_axis_udp_tdata  (tdata),
        .tx_axis_udp_tvalid (tvalid),
        .tx_axis_udp_tlast  (tlast),
        .tx_axis_udp_tuser  (tuser),
        .tx_axis_udp_tready (tready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference: per-channel config plus the words the stream must carry, in order.
    logic        m_en     [NUM_CH];
    logic [27:0] m_period [NUM_CH];
    logic [27:0] m_hlevel [NUM_CH];
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];

    bit          req_pending = 0;
    bit          check_idle  = 0;
    bit          hold_pending = 0;
    bit          last_tlast  = 0;
    int          req_cycle   = 0;
    int          last_beat_cycle = 0;
    logic [31:0] held_data;
    logic        held_last;
    int          tready_mode = 0;

    typedef struct {
        bit          cfg_vld;
        logic [7:0]  cfg_ch;
        logic        en;
        logic [27:0] period;
        logic [27:0] hlevel;
        logic [7:0]  req_ch;
        int          mode;
        int          n_words;
        logic [31:0] w [5];
    } vec_t;

    vec_t vecs [8];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_en[i]     = 1'b0;
            m_period[i] = 28'd0;
            m_hlevel[i] = 28'd0;
        end
    endfunction

    function automatic void model_cfg(input int ch, input logic en, input logic [27:0] p,
                                      input logic [27:0] h);
        if (ch < NUM_CH) begin
            m_en[ch]     = en;
            m_period[ch] = p;
            m_hlevel[ch] = h;
        end
    endfunction

    function automatic void push_frame(input int c);
        exp_q.push_back({24'b0, 8'(c)});
        exp_q.push_back({4'b0, m_period[c]});
        exp_q.push_back({4'b0, m_hlevel[c]});
        exp_q.push_back(32'd0);
        exp_q.push_back({31'b0, m_en[c]});
        for (int i = 0; i < 5; i++) exp_last_q.push_back(i == 4);
    endfunction

    // A request is taken only when no frame is outstanding and the channel is legal.
    function automatic bit model_report(input logic [7:0] ch);
        int c;
        c = int'(ch);
        if (exp_q.size() != 0) return 1'b0;
        if (c < NUM_CH) begin
            push_frame(c);
            return 1'b1;
        end
        if (ch == 8'hFF) begin
            for (int i = 0; i < NUM_CH; i++) push_frame(i);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic vec_t mk(input bit cv, input logic [7:0] cch, input logic en,
                                input logic [27:0] p, input logic [27:0] h,
                                input logic [7:0] rch, input int mode, input int nw,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] w4);
        vec_t v;
        v.cfg_vld = cv; v.cfg_ch = cch; v.en = en; v.period = p; v.hlevel = h;
        v.req_ch = rch; v.mode = mode; v.n_words = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4;
        return v;
    endfunction

    task automatic do_cfg(input logic [7:0] ch, input logic en, input logic [27:0] p,
                          input logic [27:0] h);
        pwm_config_vld     = 1'b1;
        pwm_config_channel = ch;
        pwm_en             = en;
        pwm_period         = p;
        pwm_hlevel         = h;
        model_cfg(int'(ch), en, p, h);
        tick();
        pwm_config_vld = 1'b0;
    endtask

    task automatic do_req(input logic [7:0] ch, input bit accept, input bit was_idle);
        rpt_channel = ch;
        rpt_req     = 1'b1;
        if (accept) begin
            req_pending = 1'b1;
            req_cycle   = cycle_cnt;
        end
        @(negedge clk);
        if (was_idle) check_eq("busy_before_accept", 32'(rpt_busy), 32'd0);
        tick();
        rpt_req = 1'b0;
        @(negedge clk);
        if (was_idle) check_eq("busy_after_req", 32'(rpt_busy), 32'(accept));
        tick();
    endtask

    task automatic report(input logic [7:0] ch);
        bit was_idle;
        bit acc;
        was_idle = (exp_q.size() == 0);
        acc      = model_report(ch);
        do_req(ch, acc, was_idle);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_last_q.delete();
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        exp_q.delete();
        exp_last_q.delete();
        req_pending = 1'b0;
    endtask

    initial begin
        logic [5:0] pat;
        int         pat_idx;
        pat     = 6'b101001;
        pat_idx = 0;
        tready  = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (tready_mode)
                0: tready = 1'b1;
                1: begin
                    tready  = pat[pat_idx];
                    pat_idx = (pat_idx + 1) % 6;
                end
                2: tready = ($urandom_range(0, 3) != 0);
                default: tready = 1'b0;
            endcase
        end
    end

    // Stream monitor, sampled on the falling edge.
    always @(negedge clk) begin
        bit          first_beat;
        logic [31:0] w;
        logic        l;
        first_beat = 1'b0;
        if (rst) begin
            hold_pending = 1'b0;
            check_idle   = 1'b0;
        end else begin
            if (check_idle) begin
                check_eq("idle_busy", 32'(rpt_busy), 32'd0);
                check_eq("idle_tvalid", 32'(tvalid), 32'd0);
                check_idle = 1'b0;
            end
            if (hold_pending) begin
                check_eq("hold_tvalid", 32'(tvalid), 32'd1);
                check_eq("hold_tdata", tdata, held_data);
                check_eq("hold_tlast", 32'(tlast), 32'(held_last));
            end
            if (req_pending && tvalid) begin
                check_eq("first_valid_latency", 32'(cycle_cnt), 32'(req_cycle + 2));
                req_pending = 1'b0;
                first_beat  = 1'b1;
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat (cycle %0d)",
                             tdata, cycle_cnt);
                end else begin
                    w = exp_q.pop_front();
                    l = exp_last_q.pop_front();
                    check_eq("tdata", tdata, w);
                    check_eq("tlast", 32'(tlast), 32'(l));
                    check_eq("tuser", 32'(tuser), 32'(ID));
                    if (tready_mode == 0 && !first_beat) begin
                        if (last_tlast)
                            check_eq("frame_gap", 32'(cycle_cnt - last_beat_cycle), 32'd2);
                        else
                            check_eq("beat_spacing", 32'(cycle_cnt - last_beat_cycle), 32'd1);
                    end
                    if (exp_q.size() == 0) check_idle = 1'b1;
                end
                last_beat_cycle = cycle_cnt;
                last_tlast      = tlast;
            end
            hold_pending = tvalid && !tready;
            held_data    = tdata;
            held_last    = tlast;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        logic [7:0]  ch;
        int          r;
        int          n;

        pwm_config_vld = 1'b0; pwm_config_channel = 8'd0; pwm_en = 1'b0;
        pwm_period = 28'd0; pwm_hlevel = 28'd0; rpt_req = 1'b0; rpt_channel = 8'd0;
        rst = 1'b1;
        model_clear();
        tick();
        do_reset();

        @(negedge clk);
        check_eq("reset_tvalid", 32'(tvalid), 32'd0);
        check_eq("reset_tlast", 32'(tlast), 32'd0);
        check_eq("reset_busy", 32'(rpt_busy), 32'd0);
        check_eq("reset_tdata", tdata, 32'd0);
        check_eq("reset_tuser", 32'(tuser), 32'(ID));
        tick();

        vecs[0] = mk(1, 8'd2, 1'b1, 28'd100000, 28'd50000, 8'd2, 0, 5,
                     32'h2, 32'h186A0, 32'hC350, 32'h0, 32'h1);
        vecs[1] = mk(1, 8'd7, 1'b0, 28'hFFFFFFF, 28'd1, 8'd7, 0, 5,
                     32'h7, 32'h0FFFFFFF, 32'h1, 32'h0, 32'h0);
        vecs[2] = mk(1, 8'd0, 1'b1, 28'd1, 28'd0, 8'd0, 2, 5,
                     32'h0, 32'h1, 32'h0, 32'h0, 32'h1);
        vecs[3] = mk(1, 8'd8, 1'b1, 28'd5, 28'd5, 8'd8, 0, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[4] = mk(1, 8'hF0, 1'b1, 28'd7, 28'd7, 8'd2, 1, 5,
                     32'h2, 32'h186A0, 32'hC350, 32'h0, 32'h1);
        vecs[5] = mk(1, 8'd5, 1'b1, 28'hABCDEF, 28'h123456, 8'd9, 0, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[6] = mk(0, 8'd0, 1'b0, 28'd0, 28'd0, 8'd5, 1, 5,
                     32'h5, 32'hABCDEF, 32'h123456, 32'h0, 32'h1);
        vecs[7] = mk(0, 8'd0, 1'b0, 28'd0, 28'd0, 8'hFE, 0, 0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].cfg_vld) do_cfg(vecs[v].cfg_ch, vecs[v].en, vecs[v].period, vecs[v].hlevel);
            tready_mode = vecs[v].mode;
            for (int i = 0; i < vecs[v].n_words; i++) begin
                exp_q.push_back(vecs[v].w[i]);
                exp_last_q.push_back(i == 4);
            end
            do_req(vecs[v].req_ch, vecs[v].n_words != 0, 1'b1);
            if (vecs[v].n_words == 0) begin
                repeat (3) begin
                    @(negedge clk);
                    check_eq("ignored_req_tvalid", 32'(tvalid), 32'd0);
                    check_eq("ignored_req_busy", 32'(rpt_busy), 32'd0);
                end
                tick();
            end else begin
                wait_drain(200, "table_drain");
            end
        end

        // All-channel report with distinct configs, tready held high.
        tready_mode = 0;
        for (int i = 0; i < NUM_CH; i++)
            do_cfg(8'(i), 1'(i % 2), 28'(1000 + i * 111), 28'(i * 7));
        report(8'hFF);
        wait_drain(400, "all_mode_drain");

        // A request while a frame is in flight is dropped.
        report(8'd3);
        repeat (2) tick();
        report(8'd5);
        wait_drain(200, "busy_drop_drain");

        // Config during SEND only affects the next frame.
        do_cfg(8'd2, 1'b1, 28'd100000, 28'd50000);
        report(8'd2);
        do_cfg(8'd2, 1'b1, 28'd200, 28'd50000);
        wait_drain(200, "cfg_during_send_drain");
        report(8'd2);
        wait_drain(200, "new_period_drain");

        // Config landing on the snapshot edge: snapshot keeps the old value.
        acc = model_report(8'd2);
        rpt_channel = 8'd2;
        rpt_req     = 1'b1;
        req_pending = acc;
        req_cycle   = cycle_cnt;
        tick();
        rpt_req = 1'b0;
        do_cfg(8'd2, 1'b0, 28'd300, 28'd30);
        wait_drain(200, "same_cycle_snapshot_drain");
        report(8'd2);
        wait_drain(200, "post_snapshot_drain");
        do_cfg(8'hF0, 1'b1, 28'd999, 28'd999);
        report(8'd2);
        wait_drain(200, "cfg_f0_drain");

        // Reset in the middle of a frame.
        report(8'd2);
        n = 0;
        while (exp_q.size() > 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_setup_words_left", 32'(exp_q.size()), 32'd3);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_eq("rst_mid_tvalid", 32'(tvalid), 32'd0);
        check_eq("rst_mid_tlast", 32'(tlast), 32'd0);
        check_eq("rst_mid_busy", 32'(rpt_busy), 32'd0);
        tick();
        rst = 1'b0;
        model_clear();
        exp_q.delete();
        exp_last_q.delete();
        req_pending = 1'b0;
        report(8'd2);
        wait_drain(200, "post_reset_drain");

        // Random configs and reports under random backpressure.
        tready_mode = 2;
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 11);
                ch = (r < 10) ? 8'(r) : ((r == 10) ? 8'hF0 : 8'hFF);
                do_cfg(ch, 1'($urandom_range(0, 1)), 28'($urandom()), 28'($urandom()));
            end
            r = $urandom_range(0, 11);
            if (r < 8) ch = 8'(r);
            else if (r < 10) ch = 8'hFF;
            else ch = 8'($urandom_range(8, 254));
            report(ch);
            wait_drain(1500, "random_drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
